// File: rtl/tanimoto_ctrl_pkg.sv
// Shared state encoding and width helper for the Tanimoto run controller.
package tanimoto_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_CMP = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } ctrl_state_e;

    // Threshold address/data width; never narrower than one bit.
    function automatic int cnt_width(input int vec_width);
        return (vec_width < 2) ? 1 : $clog2(vec_width);
    endfunction

endpackage

// File: rtl/tanimoto_thr_loader.sv
// Threshold loader: accepts THR_ENTRIES words and issues one registered BRAM write per handshake.
module tanimoto_thr_loader #(
    parameter int CNT_WIDTH   = 10,
    parameter int THR_ENTRIES = 920
) (
    input  logic                 ap_clk,
    input  logic                 ap_rstn,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 abort_i,
    input  logic [CNT_WIDTH-1:0] thr_tdata_i,
    input  logic                 thr_tvalid_i,
    output logic                 thr_tready_o,
    output logic [CNT_WIDTH-1:0] bram_addr_o,
    output logic [CNT_WIDTH-1:0] bram_din_o,
    output logic                 bram_en_o,
    output logic                 bram_wren_o,
    output logic                 done_o
);

    // One extra bit so a full 2**CNT_WIDTH table can be counted.
    localparam logic [CNT_WIDTH:0] FULL = (CNT_WIDTH+1)'(THR_ENTRIES);
    localparam logic [CNT_WIDTH:0] LAST = (CNT_WIDTH+1)'(THR_ENTRIES - 1);

    logic [CNT_WIDTH:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0] din_q, din_d;
    logic                 wr_q, wr_d;
    logic                 hs;

    // Abort withdraws ready so a beat arriving with it never becomes a write.
    assign thr_tready_o = en_i && !abort_i && (cnt_q != FULL);
    assign hs           = thr_tready_o && thr_tvalid_i;
    assign done_o       = hs && (cnt_q == LAST);

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        din_d  = din_q;
        wr_d   = hs;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = cnt_q[CNT_WIDTH-1:0];
            din_d  = thr_tdata_i;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            cnt_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            wr_q   <= wr_d;
        end
    end

    assign bram_addr_o = addr_q;
    assign bram_din_o  = din_q;
    assign bram_en_o   = wr_q;
    assign bram_wren_o = wr_q;

endmodule

// File: rtl/tanimoto_run_ctrl.sv
// Run-level controller: loads thresholds, passes the vector stream, waits for compare/drain completion.
// Optional watchdog on WAIT_CMP/DRAIN enabled by defining TANIMOTO_CTRL_WDOG_EN.
module tanimoto_run_ctrl
    import tanimoto_ctrl_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
    parameter int THR_ENTRIES  = 920,
    parameter int BUS_WIDTH    = 128,
    parameter int WDOG_CYCLES  = 65535
) (
    input  logic                 ap_clk,
    input  logic                 ap_rstn,
    input  logic                 i_Start,
    input  logic                 i_Abort,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Error,
    output logic [2:0]           o_State,
    output logic [31:0]          o_VecBeats,
    input  logic [CNT_WIDTH-1:0] S_AXIS_THR_tdata,
    input  logic                 S_AXIS_THR_tvalid,
    output logic                 S_AXIS_THR_tready,
    input  logic [BUS_WIDTH-1:0] S_AXIS_IN_tdata,
    input  logic                 S_AXIS_IN_tvalid,
    input  logic                 S_AXIS_IN_tlast,
    output logic                 S_AXIS_IN_tready,
    output logic [BUS_WIDTH-1:0] M_AXIS_ACC_tdata,
    output logic                 M_AXIS_ACC_tvalid,
    output logic                 M_AXIS_ACC_tlast,
    input  logic                 M_AXIS_ACC_tready,
    output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
    output logic [CNT_WIDTH-1:0] o_BRAM_Din,
    output logic                 o_BRAM_En,
    output logic                 o_BRAM_WrEn,
    input  logic                 i_CmpOver,
    input  logic                 i_FifoTreeEmpty,
    input  logic                 i_IDPairValid,
    input  logic                 i_IDPairReady,
    input  logic                 i_IDPairLast
);

    ctrl_state_e state_q, state_d;
    logic [31:0] vec_beats_q, vec_beats_d;
    logic        last_seen_q, last_seen_d;
    logic        start_run, in_stream, vec_hs, idp_last_hs, ld_done;

    assign start_run   = (state_q == ST_IDLE) && i_Start;
    assign in_stream   = (state_q == ST_STREAM);
    assign vec_hs      = in_stream && S_AXIS_IN_tvalid && M_AXIS_ACC_tready;
    assign idp_last_hs = i_IDPairValid && i_IDPairReady && i_IDPairLast;

    tanimoto_thr_loader #(
        .CNT_WIDTH   (CNT_WIDTH),
        .THR_ENTRIES (THR_ENTRIES)
    ) u_loader (
        .ap_clk       (ap_clk),
        .ap_rstn      (ap_rstn),
        .clr_i        (start_run),
        .en_i         (state_q == ST_LOAD),
        .abort_i      (i_Abort),
        .thr_tdata_i  (S_AXIS_THR_tdata),
        .thr_tvalid_i (S_AXIS_THR_tvalid),
        .thr_tready_o (S_AXIS_THR_tready),
        .bram_addr_o  (o_BRAM_Addr),
        .bram_din_o   (o_BRAM_Din),
        .bram_en_o    (o_BRAM_En),
        .bram_wren_o  (o_BRAM_WrEn),
        .done_o       (ld_done)
    );

`ifdef TANIMOTO_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            error_q, error_d;
    logic            wdog_hit;

    // Firing on the last counted cycle lands DONE exactly WDOG_CYCLES after entering WAIT_CMP.
    assign wdog_hit = ((state_q == ST_WAIT_CMP) || (state_q == ST_DRAIN)) &&
                      (wdog_q == WD_W'(WDOG_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        vec_beats_d = vec_beats_q;
        last_seen_d = last_seen_q;

        case (state_q)
            ST_IDLE:     if (i_Start) state_d = ST_LOAD;
            ST_LOAD:     if (ld_done) state_d = ST_STREAM;
            ST_STREAM:   if (vec_hs && S_AXIS_IN_tlast) state_d = ST_WAIT_CMP;
            ST_WAIT_CMP: if (i_CmpOver && i_FifoTreeEmpty) state_d = ST_DRAIN;
            ST_DRAIN:    if (last_seen_q || idp_last_hs) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
`ifdef TANIMOTO_CTRL_WDOG_EN
        if (wdog_hit) state_d = ST_DONE;
`endif
        if (i_Abort && (state_q != ST_IDLE)) state_d = ST_IDLE;

        if (start_run) begin
            vec_beats_d = '0;
            last_seen_d = 1'b0;
        end else begin
            if (vec_hs) vec_beats_d = vec_beats_q + 32'd1;
            if (idp_last_hs && ((state_q == ST_STREAM) || (state_q == ST_WAIT_CMP) ||
                                (state_q == ST_DRAIN)))
                last_seen_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state_q     <= ST_IDLE;
            vec_beats_q <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_beats_q <= vec_beats_d;
            last_seen_q <= last_seen_d;
        end
    end

`ifdef TANIMOTO_CTRL_WDOG_EN
    always_comb begin
        wdog_d  = wdog_q;
        error_d = error_q;
        if ((state_d == ST_WAIT_CMP) && (state_q != ST_WAIT_CMP))
            wdog_d = '0;
        else if ((state_q == ST_WAIT_CMP) || (state_q == ST_DRAIN))
            wdog_d = wdog_q + 1'b1;
        if (start_run)
            error_d = 1'b0;
        else if (wdog_hit && !i_Abort)
            error_d = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign o_Error = error_q;
`else
    assign o_Error = 1'b0;
`endif

    // Vector path is a pure wire-through while streaming; closed otherwise.
    assign M_AXIS_ACC_tdata  = S_AXIS_IN_tdata;
    assign M_AXIS_ACC_tvalid = in_stream && S_AXIS_IN_tvalid;
    assign M_AXIS_ACC_tlast  = in_stream && S_AXIS_IN_tlast;
    assign S_AXIS_IN_tready  = in_stream && M_AXIS_ACC_tready;

    assign o_State    = state_q;
    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Done     = (state_q == ST_DONE) && !i_Abort;
    assign o_VecBeats = vec_beats_q;

endmodule

// File: tb/tb_tanimoto_run_ctrl.sv
// Directed bench for tanimoto_run_ctrl with queue scoreboards for BRAM writes and vector beats.
module tb_tanimoto_run_ctrl;

    localparam int CW = 10;
    localparam int BW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rstn;
    logic          i_Start, i_Abort;
    logic          o_Busy, o_Done, o_Error;
    logic [2:0]    o_State;
    logic [31:0]   o_VecBeats;
    logic [CW-1:0] thr_tdata;
    logic          thr_tvalid, thr_tready;
    logic [BW-1:0] in_tdata, m_tdata;
    logic          in_tvalid, in_tlast, in_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic [CW-1:0] bram_addr, bram_din;
    logic          bram_en, bram_wren;
    logic          cmp_over, fifo_empty, idp_valid, idp_ready, idp_last;

    int checks   = 0;
    int failures = 0;

    logic [2*CW-1:0] wr_q[$];
    logic [BW:0]     vec_q[$];

    tanimoto_run_ctrl #(
        .THR_ENTRIES (4),
        .BUS_WIDTH   (BW),
        .WDOG_CYCLES (10)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rstn           (ap_rstn),
        .i_Start           (i_Start),
        .i_Abort           (i_Abort),
        .o_Busy            (o_Busy),
        .o_Done            (o_Done),
        .o_Error           (o_Error),
        .o_State           (o_State),
        .o_VecBeats        (o_VecBeats),
        .S_AXIS_THR_tdata  (thr_tdata),
        .S_AXIS_THR_tvalid (thr_tvalid),
        .S_AXIS_THR_tready (thr_tready),
        .S_AXIS_IN_tdata   (in_tdata),
        .S_AXIS_IN_tvalid  (in_tvalid),
        .S_AXIS_IN_tlast   (in_tlast),
        .S_AXIS_IN_tready  (in_tready),
        .M_AXIS_ACC_tdata  (m_tdata),
        .M_AXIS_ACC_tvalid (m_tvalid),
        .M_AXIS_ACC_tlast  (m_tlast),
        .M_AXIS_ACC_tready (m_tready),
        .o_BRAM_Addr       (bram_addr),
        .o_BRAM_Din        (bram_din),
        .o_BRAM_En         (bram_en),
        .o_BRAM_WrEn       (bram_wren),
        .i_CmpOver         (cmp_over),
        .i_FifoTreeEmpty   (fifo_empty),
        .i_IDPairValid     (idp_valid),
        .i_IDPairReady     (idp_ready),
        .i_IDPairLast      (idp_last)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Scoreboard side: every write and every accelerator beat must match the head of its queue.
    always @(negedge ap_clk) begin
        if (ap_rstn && bram_en) begin
            if (wr_q.size() == 0) chk("bram_unexpected_write", {bram_addr, bram_din}, '1);
            else chk("bram_write", {bram_wren, bram_addr, bram_din}, {1'b1, wr_q.pop_front()});
        end
        if (ap_rstn && m_tvalid && m_tready) begin
            if (vec_q.size() == 0) chk("acc_unexpected_beat", {m_tlast, m_tdata}, '1);
            else chk("acc_beat", {m_tlast, m_tdata}, vec_q.pop_front());
        end
    end

    task automatic start_run();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        chk("state_load", o_State, 1);
    endtask

    task automatic load_thr(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            thr_tvalid = 1'b1;
            thr_tdata  = CW'(base + i);
            wr_q.push_back({CW'(i), CW'(base + i)});
            tick();
            chk("bram_en_after_hs", bram_en, 1'b1);
        end
    endtask

    task automatic send_vec(input logic [BW-1:0] d, input logic last);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = last;
        m_tready  = 1'b1;
        vec_q.push_back({last, d});
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    initial begin
        ap_rstn = 1'b0;
        {i_Start, i_Abort, thr_tvalid, in_tvalid, in_tlast, m_tready} = '0;
        {cmp_over, fifo_empty, idp_valid, idp_ready, idp_last} = '0;
        thr_tdata = '0;
        in_tdata  = '0;
        #12;
        chk("rst_state", o_State, 0);
        chk("rst_outs", {o_Busy, o_Done, o_Error, bram_en, bram_wren, thr_tready, in_tready, m_tvalid}, 0);
        chk("rst_bram", {bram_addr, bram_din}, 0);
        tick();
        ap_rstn = 1'b1;
        tick();
        chk("idle_hold", o_State, 0);

        // Run 1: full load, stall of a fifth beat, three vector beats, normal completion.
        start_run();
        chk("load_busy_ready", {o_Busy, thr_tready, in_tready}, 3'b110);
        load_thr(4, 5);
        thr_tvalid = 1'b1;
        thr_tdata  = CW'(9);
        chk("state_stream", o_State, 2);
        chk("thr_stalled", thr_tready, 1'b0);
        tick();
        chk("no_fifth_write", bram_en, 1'b0);
        thr_tvalid = 1'b0;

        in_tvalid = 1'b1;
        in_tdata  = 32'hDEAD_0000;
        m_tready  = 1'b0;
        #1;
        chk("bp_ready_valid", {in_tready, m_tvalid}, 2'b01);
        tick();
        chk("bp_no_count", o_VecBeats, 0);
        send_vec(32'hA1A1_0001, 1'b0);
        send_vec(32'hB2B2_0002, 1'b0);
        send_vec(32'hC3C3_0003, 1'b1);
        chk("vec_beats", o_VecBeats, 3);
        chk("state_wait", o_State, 3);
        chk("closed_path", {in_tready, m_tvalid}, 2'b00);

        cmp_over = 1'b1;
        tick();
        chk("cmp_needs_empty", o_State, 3);
        fifo_empty = 1'b1;
        tick();
        chk("state_drain", o_State, 4);
        cmp_over = 1'b0;
        tick();
        chk("drain_waits", o_State, 4);
        {idp_valid, idp_ready, idp_last} = 3'b111;
        tick();
        {idp_valid, idp_ready, idp_last} = 3'b000;
        chk("state_done", {o_State, o_Done, o_Busy, o_Error}, {3'd5, 3'b110});
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        chk("done_to_idle", {o_State, o_Done, o_Busy}, {3'd0, 2'b00});

        // Run 2: ID-pair last seen before compare completes; DRAIN exits immediately.
        start_run();
        load_thr(4, 20);
        send_vec(32'h0000_0077, 1'b1);
        chk("r2_wait", o_State, 3);
        {idp_valid, idp_ready, idp_last} = 3'b111;
        tick();
        {idp_valid, idp_ready, idp_last} = 3'b000;
        cmp_over = 1'b1;
        tick();
        cmp_over = 1'b0;
        chk("r2_drain", o_State, 4);
        tick();
        chk("r2_done", {o_State, o_Done}, {3'd5, 1'b1});
        tick();
        chk("r2_idle", o_State, 0);

        // Run 3: abort after two writes with a third beat still offered.
        start_run();
        load_thr(2, 40);
        thr_tvalid = 1'b1;
        thr_tdata  = CW'(42);
        i_Abort    = 1'b1;
        #1;
        chk("abort_ready", thr_tready, 1'b0);
        tick();
        i_Abort    = 1'b0;
        chk("abort_idle", {o_State, o_Done, o_Busy, bram_en}, 0);
        tick();
        thr_tvalid = 1'b0;
        chk("abort_no_write", bram_en, 1'b0);

`ifdef TANIMOTO_CTRL_WDOG_EN
        // Run 4: compare never completes; watchdog forces DONE with error.
        start_run();
        chk("wd_err_cleared", o_Error, 1'b0);
        load_thr(4, 60);
        send_vec(32'h0000_0099, 1'b1);
        fifo_empty = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("wd_still_wait", o_State, 3);
        tick();
        chk("wd_done_err", {o_State, o_Done, o_Error}, {3'd5, 2'b11});
        tick();
        chk("wd_idle", o_State, 0);
`endif

        tick();
        chk("wr_q_empty", wr_q.size(), 0);
        chk("vec_q_empty", vec_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
